// File: rtl/hazard_multicycle_stall_resolver_pkg.sv
// rtl/hazard_multicycle_stall_resolver_pkg.sv - ALU op / mul-div class types and latency defaults
package hazard_multicycle_stall_resolver_pkg;

  localparam int unsigned MUL_COUNT = 4;
  localparam int unsigned DIV_COUNT = 34;

  typedef enum logic [3:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_AND,
    ALUOP_OR,
    ALUOP_XOR,
    ALUOP_SLT,
    ALUOP_SLL,
    ALUOP_SRL,
    ALUOP_MUL,
    ALUOP_DIV
  } aluop_t;

  typedef enum logic [1:0] {
    MDC_NONE,
    MDC_MUL,
    MDC_DIV
  } muldiv_class_t;

  function automatic muldiv_class_t aluop_to_mdclass(input aluop_t op);
    case (op)
      ALUOP_MUL: return MDC_MUL;
      ALUOP_DIV: return MDC_DIV;
      default:   return MDC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_multicycle_stall_resolver_perf.sv
// rtl/hazard_multicycle_stall_resolver_perf.sv - saturating event counter
module perf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         start,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_multicycle_stall_resolver.sv
// rtl/hazard_multicycle_stall_resolver.sv - holds IF/ID/EX while one mul/div op is in flight
module hazard_multicycle_stall_resolver
  import hazard_multicycle_stall_resolver_pkg::*;
#(
  parameter int unsigned MUL_LAT      = MUL_COUNT,
  parameter int unsigned DIV_LAT      = DIV_COUNT,
  parameter int unsigned CNT_W        = 6,
  parameter bit          MUL_EARLY_EN = 1'b0,
  parameter bit          DIV_EARLY_EN = 1'b1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              start,
  input  logic              ex_fire,
  input  aluop_t            aluop_e,
  input  logic              flush_e,
  input  logic              unit_done,
  output logic              flag,
  output logic              stall,
  output logic              complete,
  output muldiv_class_t     busy_class,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam longint unsigned LAT_MAX = 64'd1 << CNT_W;

  if (64'(MUL_LAT) > LAT_MAX) begin : g_mul_lat_chk
    $fatal(1, "MUL_LAT does not fit the remaining-cycle counter");
  end
  if (64'(DIV_LAT) > LAT_MAX) begin : g_div_lat_chk
    $fatal(1, "DIV_LAT does not fit the remaining-cycle counter");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  muldiv_class_t    class_q, class_d;
  logic             early_q, early_d;

  muldiv_class_t issue_class;
  int unsigned   issue_lat;
  logic          issue_early;
  logic          exec_init;
  logic          busy_last;

  always_comb begin
    issue_class = aluop_to_mdclass(aluop_e);
    issue_lat   = (issue_class == MDC_DIV) ? DIV_LAT : MUL_LAT;
    issue_early = (issue_class == MDC_DIV) ? DIV_EARLY_EN : MUL_EARLY_EN;
    exec_init   = start && ex_fire && (issue_class != MDC_NONE) &&
                  (state_q == ST_IDLE) && (issue_lat != 32'd0);
    // unit_done only counts once BUSY, so an issue-cycle strobe can never cut an op short
    busy_last   = (state_q == ST_BUSY) &&
                  ((rem_q == CNT_W'(1)) || (early_q && unit_done));

    stall    = start && (exec_init || (state_q == ST_BUSY));
    flag     = stall;
    complete = start && !flush_e &&
               ((exec_init && (issue_lat == 32'd1)) || busy_last);

    busy_class = MDC_NONE;
    if (start) begin
      if (exec_init) begin
        busy_class = issue_class;
      end else if (state_q == ST_BUSY) begin
        busy_class = class_q;
      end
    end

    state_d = state_q;
    rem_d   = rem_q;
    class_d = class_q;
    early_d = early_q;
    if (flush_e) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      class_d = MDC_NONE;
      early_d = 1'b0;
    end else if (exec_init && (issue_lat > 32'd1)) begin
      state_d = ST_BUSY;
      rem_d   = CNT_W'(issue_lat - 32'd1);
      class_d = issue_class;
      early_d = issue_early;
    end else if (busy_last) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      class_d = MDC_NONE;
      early_d = 1'b0;
    end else if (state_q == ST_BUSY) begin
      rem_d = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      class_q <= MDC_NONE;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      class_q <= class_d;
      early_q <= early_d;
    end
  end

  perf_sat_counter #(
    .W(PERF_W)
  ) u_perf (
    .clk  (clk),
    .start(start),
    .inc  (stall),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_multicycle_stall_resolver.sv
// tb/tb_hazard_multicycle_stall_resolver.sv - scoreboard bench for the mul/div stall resolver
module tb_hazard_multicycle_stall_resolver;
  import hazard_multicycle_stall_resolver_pkg::*;

  logic   clk = 1'b0;
  logic   start = 1'b0;
  logic   ex_fire = 1'b0;
  aluop_t aluop_e = ALUOP_ADD;
  logic   flush_e = 1'b0;
  logic   unit_done = 1'b0;

  logic m_flag, m_stall, m_complete;
  muldiv_class_t m_class;
  logic [31:0] m_cycles;
  logic z_flag, z_stall, z_complete;
  muldiv_class_t z_class;
  logic [31:0] z_cycles;
  logic o_flag, o_stall, o_complete;
  muldiv_class_t o_class;
  logic [31:0] o_cycles;
  logic s_flag, s_stall, s_complete;
  muldiv_class_t s_class;
  logic [2:0] s_cycles;

  always #5 clk = ~clk;

  hazard_multicycle_stall_resolver #(.MUL_LAT(4), .DIV_LAT(8), .MUL_EARLY_EN(1'b0), .DIV_EARLY_EN(1'b1)) u_main (
    .clk(clk), .start(start), .ex_fire(ex_fire), .aluop_e(aluop_e), .flush_e(flush_e),
    .unit_done(unit_done), .flag(m_flag), .stall(m_stall), .complete(m_complete),
    .busy_class(m_class), .stall_cycles(m_cycles));

  hazard_multicycle_stall_resolver #(.MUL_LAT(0), .DIV_LAT(8)) u_lat0 (
    .clk(clk), .start(start), .ex_fire(ex_fire), .aluop_e(aluop_e), .flush_e(flush_e),
    .unit_done(unit_done), .flag(z_flag), .stall(z_stall), .complete(z_complete),
    .busy_class(z_class), .stall_cycles(z_cycles));

  hazard_multicycle_stall_resolver #(.MUL_LAT(1), .DIV_LAT(8)) u_lat1 (
    .clk(clk), .start(start), .ex_fire(ex_fire), .aluop_e(aluop_e), .flush_e(flush_e),
    .unit_done(unit_done), .flag(o_flag), .stall(o_stall), .complete(o_complete),
    .busy_class(o_class), .stall_cycles(o_cycles));

  hazard_multicycle_stall_resolver #(.MUL_LAT(4), .DIV_LAT(8), .PERF_W(3)) u_sat (
    .clk(clk), .start(start), .ex_fire(ex_fire), .aluop_e(aluop_e), .flush_e(flush_e),
    .unit_done(unit_done), .flag(s_flag), .stall(s_stall), .complete(s_complete),
    .busy_class(s_class), .stall_cycles(s_cycles));

  typedef struct {
    logic          stall;
    logic          comp;
    muldiv_class_t cls;
    bit            chk_perf;
    logic [31:0]   perf;
    bit            chk_sat;
    logic [2:0]    sat;
    bit            chk_aux;
    logic          l0_stall;
    logic          l1_stall;
    logic          l1_comp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;

  bit          p_chk_perf = 1'b0;
  logic [31:0] p_perf = '0;
  bit          p_chk_sat = 1'b0;
  logic [2:0]  p_sat = '0;
  bit          p_chk_aux = 1'b0;
  logic        p_l0 = 1'b0, p_l1s = 1'b0, p_l1c = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_perf(input int v);
    p_chk_perf = 1'b1;
    p_perf     = 32'(v);
  endtask

  task automatic exp_sat(input int v);
    p_chk_sat = 1'b1;
    p_sat     = 3'(v);
  endtask

  task automatic exp_aux(input logic l0, input logic l1s, input logic l1c);
    p_chk_aux = 1'b1;
    p_l0 = l0; p_l1s = l1s; p_l1c = l1c;
  endtask

  task automatic step(input logic rst_n, input logic fire, input aluop_t op, input logic flush,
                      input logic done, input logic e_stall, input logic e_comp,
                      input muldiv_class_t e_cls);
    exp_t e;
    @(posedge clk);
    #1;
    start = rst_n; ex_fire = fire; aluop_e = op; flush_e = flush; unit_done = done;
    e.stall = e_stall; e.comp = e_comp; e.cls = e_cls;
    e.chk_perf = p_chk_perf; e.perf = p_perf;
    e.chk_sat = p_chk_sat; e.sat = p_sat;
    e.chk_aux = p_chk_aux; e.l0_stall = p_l0; e.l1_stall = p_l1s; e.l1_comp = p_l1c;
    exp_q.push_back(e);
    p_chk_perf = 1'b0; p_chk_sat = 1'b0; p_chk_aux = 1'b0;
  endtask

  task automatic hold(input int n, input muldiv_class_t cls);
    for (int i = 0; i < n; i++) step(1, 0, ALUOP_ADD, 0, 0, 1, 0, cls);
  endtask

  task automatic idle_chk(input int perf, input int sat);
    exp_perf(perf);
    exp_sat(sat);
    step(1, 0, ALUOP_ADD, 0, 0, 0, 0, MDC_NONE);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_eq("stall", 32'(m_stall), 32'(mon_e.stall));
      check_eq("flag", 32'(m_flag), 32'(mon_e.stall));
      check_eq("complete", 32'(m_complete), 32'(mon_e.comp));
      check_eq("busy_class", 32'(m_class), 32'(mon_e.cls));
      if (mon_e.chk_perf) check_eq("stall_cycles", m_cycles, mon_e.perf);
      if (mon_e.chk_sat) check_eq("sat_cycles", 32'(s_cycles), 32'(mon_e.sat));
      if (mon_e.chk_aux) begin
        check_eq("lat0_stall", 32'(z_stall), 32'(mon_e.l0_stall));
        check_eq("lat1_stall", 32'(o_stall), 32'(mon_e.l1_stall));
        check_eq("lat1_complete", 32'(o_complete), 32'(mon_e.l1_comp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset, including a MUL presented while reset is held
    exp_aux(0, 0, 0); step(0, 0, ALUOP_ADD, 0, 0, 0, 0, MDC_NONE);
    exp_aux(0, 0, 0); exp_perf(0); step(0, 1, ALUOP_MUL, 0, 0, 0, 0, MDC_NONE);

    // MUL, full 4 cycles; a DIV offered while busy is ignored
    exp_aux(0, 1, 1); step(1, 1, ALUOP_MUL, 0, 0, 1, 0, MDC_MUL);
    step(1, 1, ALUOP_DIV, 0, 0, 1, 0, MDC_MUL);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 0, MDC_MUL);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 1, MDC_MUL);
    idle_chk(4, 4);

    // DIV with early done at cycle 2; done in the issue cycle is ignored
    step(1, 1, ALUOP_DIV, 0, 1, 1, 0, MDC_DIV);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 0, MDC_DIV);
    step(1, 0, ALUOP_ADD, 0, 1, 1, 1, MDC_DIV);
    idle_chk(7, 7);

    // MUL ignores unit_done
    step(1, 1, ALUOP_MUL, 0, 0, 1, 0, MDC_MUL);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 0, MDC_MUL);
    step(1, 0, ALUOP_ADD, 0, 1, 1, 0, MDC_MUL);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 1, MDC_MUL);
    idle_chk(11, 7);

    // DIV flushed at cycle 3
    step(1, 1, ALUOP_DIV, 0, 0, 1, 0, MDC_DIV);
    hold(2, MDC_DIV);
    step(1, 0, ALUOP_ADD, 1, 0, 1, 0, MDC_DIV);
    idle_chk(15, 7);

    // DIV flushed in its final cycle: no completion
    step(1, 1, ALUOP_DIV, 0, 0, 1, 0, MDC_DIV);
    hold(6, MDC_DIV);
    step(1, 0, ALUOP_ADD, 1, 0, 1, 0, MDC_DIV);
    idle_chk(23, 7);

    // MUL then DIV back to back, no bubble
    step(1, 1, ALUOP_MUL, 0, 0, 1, 0, MDC_MUL);
    hold(2, MDC_MUL);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 1, MDC_MUL);
    step(1, 1, ALUOP_DIV, 0, 0, 1, 0, MDC_DIV);
    hold(6, MDC_DIV);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 1, MDC_DIV);
    idle_chk(35, 7);

    // reset mid-DIV, then ADD, then MUL flushed in its issue cycle
    step(1, 1, ALUOP_DIV, 0, 0, 1, 0, MDC_DIV);
    step(1, 0, ALUOP_ADD, 0, 0, 1, 0, MDC_DIV);
    step(0, 0, ALUOP_ADD, 0, 0, 0, 0, MDC_NONE);
    exp_perf(0); exp_sat(0); exp_aux(0, 0, 0);
    step(1, 1, ALUOP_ADD, 0, 0, 0, 0, MDC_NONE);
    exp_aux(0, 1, 0); step(1, 1, ALUOP_MUL, 1, 0, 1, 0, MDC_MUL);
    idle_chk(1, 1);

    repeat (2) @(posedge clk);
    #1;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
